// File: rtl/systolic_pkg.sv
// Shared constants and types for the 4x4 systolic array feeder.
// Element width, array size, stream length, FSM states, write selects.
package systolic_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ARRAY_N    = 4;
  localparam int MEM_DEPTH  = ARRAY_N * ARRAY_N;
  localparam int STREAM_LEN = 3 * ARRAY_N - 2;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/systolic_feeder_lane.sv
// One skewed feeder lane: registers elems[t-LANE] while in window, else 0.
// Used for both activation rows and weight columns.
module systolic_feeder_lane
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = systolic_pkg::DATA_WIDTH,
  parameter int LANE       = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic [CNT_W-1:0]                   t,
  input  logic [ARRAY_N-1:0][DATA_WIDTH-1:0] elems,
  output logic [DATA_WIDTH-1:0]              q
);

  logic [CNT_W-1:0] k;
  logic             hit;

  assign k   = t - CNT_W'(LANE);
  assign hit = en
            && (t >= CNT_W'(LANE))
            && (k < CNT_W'(ARRAY_N));

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= hit ? elems[k[1:0]] : '0;
  end

endmodule

// File: rtl/systolic_feeder_4x4.sv
// Matrix store plus skewed A-row / B-column streamer for the 4x4 MAC array.
// FEEDER_PINGPONG_EN: two storage banks, writes always go to the shadow bank.
module systolic_feeder_4x4
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = systolic_pkg::DATA_WIDTH,
  parameter int ARRAY_N    = systolic_pkg::ARRAY_N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [3:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] a_out0,
  output logic [DATA_WIDTH-1:0] a_out1,
  output logic [DATA_WIDTH-1:0] a_out2,
  output logic [DATA_WIDTH-1:0] a_out3,
  output logic [DATA_WIDTH-1:0] b_out0,
  output logic [DATA_WIDTH-1:0] b_out1,
  output logic [DATA_WIDTH-1:0] b_out2,
  output logic [DATA_WIDTH-1:0] b_out3,
  output logic                  we_out
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STREAM_LEN - 1);

  state_t           state;
  logic [CNT_W-1:0] t;
  logic [CNT_W-1:0] t_nx;
  logic             go;
  logic             last;
  logic             emit;

  logic [DATA_WIDTH-1:0] rd_a [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_b [MEM_DEPTH];

  assign go   = (state == IDLE) && start;
  assign last = (state == STREAM) && (t == LAST);
  assign emit = go || ((state == STREAM) && !last);
  assign t_nx = go ? '0 : t + 1'b1;

  // Lanes read the post-edge storage so a same-cycle write is streamed.
`ifdef FEEDER_PINGPONG_EN
  logic [DATA_WIDTH-1:0] a_mem [2][MEM_DEPTH];
  logic [DATA_WIDTH-1:0] b_mem [2][MEM_DEPTH];
  logic [DATA_WIDTH-1:0] a_nxt [2][MEM_DEPTH];
  logic [DATA_WIDTH-1:0] b_nxt [2][MEM_DEPTH];
  logic                  bank;
  logic                  bank_d;

  assign bank_d = bank ^ go;

  always_comb begin
    a_nxt = a_mem;
    b_nxt = b_mem;
    if (wr_en) begin
      if (wr_sel == SEL_A) a_nxt[~bank][wr_addr] = wr_data;
      else                 b_nxt[~bank][wr_addr] = wr_data;
    end
    rd_a = a_nxt[bank_d];
    rd_b = b_nxt[bank_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_mem <= '{default: '{default: '0}};
      b_mem <= '{default: '{default: '0}};
      bank  <= 1'b0;
    end else begin
      a_mem <= a_nxt;
      b_mem <= b_nxt;
      bank  <= bank_d;
    end
  end
`else
  logic [DATA_WIDTH-1:0] a_mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] b_mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] a_nxt [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] b_nxt [MEM_DEPTH];

  always_comb begin
    a_nxt = a_mem;
    b_nxt = b_mem;
    if (wr_en && (state != STREAM)) begin
      if (wr_sel == SEL_A) a_nxt[wr_addr] = wr_data;
      else                 b_nxt[wr_addr] = wr_data;
    end
    rd_a = a_nxt;
    rd_b = b_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_mem <= '{default: '0};
      b_mem <= '{default: '0};
    end else begin
      a_mem <= a_nxt;
      b_mem <= b_nxt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      t      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      we_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state  <= STREAM;
            t      <= '0;
            busy   <= 1'b1;
            we_out <= 1'b1;
          end
        end
        STREAM: begin
          if (t == LAST) begin
            state  <= DONE;
            busy   <= 1'b0;
            we_out <= 1'b0;
            done   <= 1'b1;
          end else begin
            t <= t + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] a_q [ARRAY_N];
  logic [DATA_WIDTH-1:0] b_q [ARRAY_N];

  for (genvar i = 0; i < ARRAY_N; i++) begin : g_lane
    logic [ARRAY_N-1:0][DATA_WIDTH-1:0] a_row;
    logic [ARRAY_N-1:0][DATA_WIDTH-1:0] b_col;

    for (genvar k = 0; k < ARRAY_N; k++) begin : g_el
      assign a_row[k] = rd_a[i*ARRAY_N+k];
      assign b_col[k] = rd_b[k*ARRAY_N+i];
    end

    systolic_feeder_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .LANE      (i)
    ) u_a (
      .clk  (clk),
      .rst  (rst),
      .en   (emit),
      .t    (t_nx),
      .elems(a_row),
      .q    (a_q[i])
    );

    systolic_feeder_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .LANE      (i)
    ) u_b (
      .clk  (clk),
      .rst  (rst),
      .en   (emit),
      .t    (t_nx),
      .elems(b_col),
      .q    (b_q[i])
    );
  end

  assign a_out0 = a_q[0];
  assign a_out1 = a_q[1];
  assign a_out2 = a_q[2];
  assign a_out3 = a_q[3];
  assign b_out0 = b_q[0];
  assign b_out1 = b_q[1];
  assign b_out2 = b_q[2];
  assign b_out3 = b_q[3];

endmodule
